// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting between the program counter
// and decode. Issues one instruction-memory read per instruction, holds the
// returned word in ir until decode accepts it, then strobes pc_en for one
// cycle so the program counter loads its pc+2 value.
module fetch_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_accept,
    input  logic              flush,
    output logic              pc_en,
    output logic              fault
);

    // A zero-bit counter is not legal, so the disabled-timeout build keeps one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Limit widened by one bit so the compare against counter+1 cannot wrap.
    localparam logic [CNT_W:0]   TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ADV   = 2'd3
    } state_e;

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [DATA_W-1:0] ir_q,       ir_d;
    logic [ADDR_W-1:0] ir_pc_q,    ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              pc_en_q,    pc_en_d;
    logic              fault_q,    fault_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [CNT_W:0]    cnt_inc;
    logic              timeout_hit;

    // Wait-cycle count after this FETCH cycle, and whether it reaches the limit.
    always_comb begin
        cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_LIM);
    end

    // Next-state and next-output computation for the fetch sequencer.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        pc_en_d    = 1'b0;
        fault_d    = fault_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // A fault parks the unit here until reset; flush suppresses a
                // fetch from a pc that is about to be redirected.
                if (run && !fault_q && !flush) begin
                    mem_addr_d = pc;
                    mem_rd_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_FETCH;
                end
            end

            S_FETCH: begin
                if (flush) begin
                    // Returned data (if any) belongs to a discarded path.
                    mem_rd_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (mem_ready) begin
                    ir_d       = mem_rdata;
                    ir_pc_d    = mem_addr_q;
                    ir_valid_d = 1'b1;
                    mem_rd_d   = 1'b0;
                    state_d    = S_HOLD;
                end else begin
                    // Saturate so the disabled-timeout build never wraps.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                    if (timeout_hit) begin
                        fault_d  = 1'b1;
                        mem_rd_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end

            S_HOLD: begin
                if (flush) begin
                    // Dropping the instruction must not advance the pc.
                    ir_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (ir_accept) begin
                    ir_valid_d = 1'b0;
                    pc_en_d    = 1'b1;
                    state_d    = S_ADV;
                end
            end

            S_ADV: begin
                // The pc loads on the edge ending this state, so the IDLE
                // that follows sees the advanced value.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything without a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            pc_en_q    <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            pc_en_q    <= pc_en_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign pc_en    = pc_en_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a program-counter
// register (pc+2 on pc_en), a memory responder with programmable wait
// states, a decode responder with programmable stall, and an output-level
// reference model compared every cycle.
module tb_fetch_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              run = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] mem_rdata = 16'hDEAD;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_accept = 1'b0;
    logic              flush = 1'b0;
    logic              pc_en;
    logic              fault;

    fetch_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pc       (pc),
        .run      (run),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_accept(ir_accept),
        .flush    (flush),
        .pc_en    (pc_en),
        .fault    (fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a * 16'd3 + 16'h1234;
    endfunction

    // Program counter: loads pc+2 when the fetch unit strobes pc_en.
    always @(posedge clock or negedge reset) begin
        if (!reset) pc <= '0;
        else if (pc_en) pc <= pc + 16'd2;
    end

    // Memory and decode responders, driven on the falling edge.
    int wait_cfg = 0;
    int acc_cfg = 0;
    int flush_mode = 0;
    bit stray = 1'b0;
    int rd_cnt = 0;
    int hold_cnt = 0;
    always @(negedge clock) begin
        logic rdy;
        logic acc;
        rdy = 1'b0;
        acc = 1'b0;
        if (mem_rd) begin
            rdy = (rd_cnt == wait_cfg);
            rd_cnt++;
        end else begin
            rd_cnt = 0;
        end
        if (ir_valid) begin
            acc = (hold_cnt == acc_cfg);
            hold_cnt++;
        end else begin
            hold_cnt = 0;
        end
        mem_ready = rdy | (stray & ~mem_rd);
        mem_rdata = rdy ? mem_word(mem_addr) : 16'hDEAD;
        ir_accept = acc | (stray & ~ir_valid);
        flush     = (flush_mode == 1 && rdy) || (flush_mode == 2 && acc);
    end

    // Reference model: predicts each output from the previous outputs and inputs.
    logic [15:0] e_mem_addr, e_ir, e_ir_pc;
    logic        e_mem_rd, e_ir_valid, e_pc_en, e_fault;
    int          e_waits;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            e_mem_addr <= '0; e_mem_rd <= 1'b0; e_ir <= '0; e_ir_pc <= '0;
            e_ir_valid <= 1'b0; e_pc_en <= 1'b0; e_fault <= 1'b0; e_waits <= 0;
        end else if (e_mem_rd) begin
            if (flush) e_mem_rd <= 1'b0;
            else if (mem_ready) begin
                e_ir <= mem_rdata; e_ir_pc <= e_mem_addr; e_ir_valid <= 1'b1; e_mem_rd <= 1'b0;
            end else if (e_waits + 1 == TIMEOUT) begin
                e_fault <= 1'b1; e_mem_rd <= 1'b0;
            end else e_waits <= e_waits + 1;
        end else if (e_ir_valid) begin
            if (flush) e_ir_valid <= 1'b0;
            else if (ir_accept) begin
                e_ir_valid <= 1'b0; e_pc_en <= 1'b1;
            end
        end else if (e_pc_en) begin
            e_pc_en <= 1'b0;
        end else if (run && !e_fault && !flush) begin
            e_mem_addr <= pc; e_mem_rd <= 1'b1; e_waits <= 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        check("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
        check("mem_rd",   32'(mem_rd),   32'(e_mem_rd));
        check("ir",       32'(ir),       32'(e_ir));
        check("ir_pc",    32'(ir_pc),    32'(e_ir_pc));
        check("ir_valid", 32'(ir_valid), 32'(e_ir_valid));
        check("pc_en",    32'(pc_en),    32'(e_pc_en));
        check("fault",    32'(fault),    32'(e_fault));
    end

    // Activity monitor: fetch start addresses/cycles, fetch lengths, strobe counts.
    int          cyc = 0;
    logic [15:0] rise_addr[$];
    int          rise_cyc[$];
    bit          prev_rd = 1'b0;
    int          cur_len = 0;
    int          last_len = 0;
    int          pcen_cycles = 0;
    int          valid_cycles = 0;
    always @(posedge clock) cyc++;
    always @(negedge clock) begin
        if (mem_rd && !prev_rd) begin
            rise_addr.push_back(mem_addr);
            rise_cyc.push_back(cyc);
        end
        if (mem_rd) cur_len++;
        else if (prev_rd) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        prev_rd = mem_rd;
        if (pc_en) pcen_cycles++;
        if (ir_valid) valid_cycles++;
    end

    // One fetch: run pulsed for a single IDLE sample, then let it drain.
    task automatic one_fetch(input int w, input int a, input int fm, input bit s);
        wait_cfg = w; acc_cfg = a; flush_mode = fm; stray = s;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        repeat (w + a + 10) @(negedge clock);
        flush_mode = 0; stray = 1'b0;
    endtask

    int r0, p0, v0, k;

    initial begin
        repeat (2) @(negedge clock);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_rd",   32'(mem_rd),   32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_pc_en",    32'(pc_en),    32'h0);
        check("rst_fault",    32'(fault),    32'h0);

        // Reset dropped asynchronously in the middle of a fetch.
        reset = 1'b1; run = 1'b1; wait_cfg = 100;
        k = 0;
        while (!mem_rd && k < 20) begin @(negedge clock); k++; end
        check("t1_fetch_started", 32'(mem_rd), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("t1_async_mem_rd",   32'(mem_rd),   32'h0);
        check("t1_async_ir_valid", 32'(ir_valid), 32'h0);
        check("t1_async_pc_en",    32'(pc_en),    32'h0);
        check("t1_async_fault",    32'(fault),    32'h0);
        @(negedge clock);
        wait_cfg = 0; acc_cfg = 0;
        rise_addr.delete(); rise_cyc.delete(); pcen_cycles = 0;
        reset = 1'b1;

        // Basic loop with zero wait states and immediate accept.
        k = 0;
        while (!ir_valid && k < 10) begin @(negedge clock); k++; end
        check("t2_ir",    32'(ir),    32'h1234);
        check("t2_ir_pc", 32'(ir_pc), 32'h0000);
        k = 0;
        while (rise_addr.size() < 3 && k < 20) begin @(negedge clock); k++; end
        run = 1'b0;
        repeat (8) @(negedge clock);
        check("t2_fetch_count", 32'(rise_addr.size()), 32'd3);
        if (rise_addr.size() >= 3) begin
            check("t2_addr0", 32'(rise_addr[0]), 32'h0000);
            check("t2_addr1", 32'(rise_addr[1]), 32'h0002);
            check("t2_addr2", 32'(rise_addr[2]), 32'h0004);
            check("t2_spacing1", 32'(rise_cyc[1] - rise_cyc[0]), 32'd4);
            check("t2_spacing2", 32'(rise_cyc[2] - rise_cyc[1]), 32'd4);
        end
        check("t2_pc_en_cycles", 32'(pcen_cycles), 32'd3);
        check("t2_pc", 32'(pc), 32'h0006);

        // Three wait states, with stray ready/accept outside their windows.
        one_fetch(3, 0, 0, 1'b1);
        check("t3_rd_len", 32'(last_len), 32'd4);
        check("t3_ir",     32'(ir),       32'h1246);
        check("t3_ir_pc",  32'(ir_pc),    32'h0006);
        check("t3_fault",  32'(fault),    32'h0);
        check("t3_pc",     32'(pc),       32'h0008);

        // Decode stall of five cycles, accept on the sixth.
        p0 = pcen_cycles; v0 = valid_cycles; r0 = rise_addr.size();
        one_fetch(0, 5, 0, 1'b0);
        check("t4_pc_en_pulses", 32'(pcen_cycles - p0), 32'd1);
        check("t4_valid_cycles", 32'(valid_cycles - v0), 32'd6);
        check("t4_fetches",      32'(rise_addr.size() - r0), 32'd1);
        check("t4_ir",           32'(ir), 32'h124C);

        // flush coinciding with accept: instruction dropped, no pc advance.
        p0 = pcen_cycles; v0 = valid_cycles;
        one_fetch(0, 0, 2, 1'b0);
        check("t5a_pc_en", 32'(pcen_cycles - p0), 32'd0);
        check("t5a_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("t5a_ir_pc", 32'(ir_pc), 32'h000A);
        check("t5a_pc",    32'(pc),    32'h000A);

        // flush coinciding with mem_ready: nothing captured.
        p0 = pcen_cycles; v0 = valid_cycles; r0 = rise_addr.size();
        one_fetch(0, 0, 1, 1'b0);
        check("t5b_fetches", 32'(rise_addr.size() - r0), 32'd1);
        check("t5b_valid_cycles", 32'(valid_cycles - v0), 32'd0);
        check("t5b_pc_en", 32'(pcen_cycles - p0), 32'd0);
        check("t5b_ir_pc", 32'(ir_pc), 32'h000A);
        check("t5b_ir",    32'(ir),    32'h1252);

        // Timeout: memory never answers.
        wait_cfg = 1000; r0 = rise_addr.size();
        run = 1'b1;
        repeat (25) @(negedge clock);
        check("t6_fault",  32'(fault),    32'h1);
        check("t6_rd_len", 32'(last_len), 32'd15);
        check("t6_fetches", 32'(rise_addr.size() - r0), 32'd1);
        r0 = rise_addr.size();
        repeat (20) @(negedge clock);
        check("t6_no_refetch", 32'(rise_addr.size() - r0), 32'd0);
        check("t6_fault_sticky", 32'(fault), 32'h1);
        run = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("t6_fault_cleared", 32'(fault), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
